// File: rtl/melody_sequencer.sv
// Tempo-divided step sequencer with play/pause/stop/loop control that drives the melody step index and note gate.
// Latency: one cycle from any command pulse to the new index or state. Backpressure: none, since commands are plain pulses.
module melody_sequencer #(
  parameter int TICKS_PER_BEAT = 6250000,
  parameter int SONG_LEN       = 159,
  parameter int GAP_TICKS      = 250000,
  parameter int CNT_W          = 24
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic [1:0] tempo_sel,
  output logic [7:0] beats,
  output logic       beat_tick,
  output logic       gate,
  output logic       playing,
  output logic       done
);

  // One extra bit so the half-speed period (2*TICKS_PER_BEAT) cannot overflow.
  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0]    P_NORM = PW'(TICKS_PER_BEAT);
  localparam logic [PW-1:0]    P_SLOW = PW'(2 * TICKS_PER_BEAT);
  localparam logic [PW-1:0]    P_FAST = PW'(TICKS_PER_BEAT / 2);
  localparam logic [7:0]       LAST   = 8'(SONG_LEN - 1);
  localparam logic [CNT_W-1:0] GAP    = CNT_W'(GAP_TICKS);
  localparam logic [7:0]       SILENT = 8'd255;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [PW-1:0]    period;
  logic [PW-1:0]    tempo_period;
  logic             at_boundary;

  always_comb begin
    tempo_period = P_NORM;
    case (tempo_sel)
      2'b01:   tempo_period = P_SLOW;
      2'b10:   tempo_period = P_FAST;
      default: tempo_period = P_NORM;
    endcase
  end

  assign at_boundary = ({1'b0, tick_cnt} == (period - PW'(1)));
  assign gate        = (state == PLAY) && (tick_cnt >= GAP);
  assign playing     = (state == PLAY) || (state == PAUSE);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beats     <= SILENT;
      tick_cnt  <= '0;
      period    <= P_NORM;
      beat_tick <= 1'b0;
      done      <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      done      <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        beats    <= SILENT;
        tick_cnt <= '0;
      end else if (start) begin
        state     <= PLAY;
        beats     <= 8'd0;
        tick_cnt  <= '0;
        beat_tick <= 1'b1;
        period    <= tempo_period;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          // The cycle carrying a pause pulse still counts as a PLAY cycle.
          PLAY: begin
            state <= pause ? PAUSE : PLAY;
            if (at_boundary) begin
              tick_cnt <= '0;
              period   <= tempo_period;
              if (beats < LAST) begin
                beats     <= beats + 8'd1;
                beat_tick <= 1'b1;
              end else if (loop_en) begin
                beats     <= 8'd0;
                beat_tick <= 1'b1;
              end else begin
                state <= DONE;
                beats <= SILENT;
                done  <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
          PAUSE: if (pause) state <= PLAY;
          DONE:  state <= IDLE;
          default: begin
            state <= IDLE;
            beats <= SILENT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a tiny song (8 ticks per step, 4 steps, 2-tick gap).
module tb_melody_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n;
  logic       start, stop, pause, loop_en;
  logic [1:0] tempo_sel;
  logic [7:0] beats;
  logic       beat_tick, gate, playing, done;

  int checks = 0;
  int errors = 0;

  melody_sequencer #(
    .TICKS_PER_BEAT(8),
    .SONG_LEN(4),
    .GAP_TICKS(2),
    .CNT_W(5)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
    .tempo_sel(tempo_sel),
    .beats    (beats),
    .beat_tick(beat_tick),
    .gate     (gate),
    .playing  (playing),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] b, input logic bt,
                            input logic g, input logic p, input logic d);
    chk($sformatf("%s.beats", tag), beats, b);
    chk($sformatf("%s.beat_tick", tag), {7'd0, beat_tick}, {7'd0, bt});
    chk($sformatf("%s.gate", tag), {7'd0, gate}, {7'd0, g});
    chk($sformatf("%s.playing", tag), {7'd0, playing}, {7'd0, p});
    chk($sformatf("%s.done", tag), {7'd0, done}, {7'd0, d});
  endtask

  // Advance through ticks first..last of a playing step; gate opens at tick 2.
  task automatic hold_step(input string tag, input logic [7:0] b, input int first, input int last);
    for (int t = first; t <= last; t++) begin
      cyc();
      expect_out($sformatf("%s.t%0d", tag, t), b, 1'b0, (t >= 2), 1'b1, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    loop_en = 1'b0; tempo_sel = 2'b00;
    repeat (3) cyc();
    expect_out("reset", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();
    expect_out("idle0", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);

    // First step timing and gate shape
    start = 1'b1; cyc(); start = 1'b0;
    expect_out("start", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    hold_step("s0", 8'd0, 1, 7);
    cyc();
    expect_out("step1", 8'd1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Play to the natural end without looping
    hold_step("s1", 8'd1, 1, 7);
    cyc();
    expect_out("step2", 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    hold_step("s2", 8'd2, 1, 7);
    cyc();
    expect_out("step3", 8'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    hold_step("s3", 8'd3, 1, 7);
    cyc();
    expect_out("done", 8'd255, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    expect_out("after_done", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    pause = 1'b1; cyc(); pause = 1'b0;
    expect_out("pause_idle", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);

    // Looping wraps the last step back to step 0 with no done strobe
    loop_en = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    expect_out("lstart", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++) begin
      hold_step($sformatf("loop%0d", s), 8'(s), 1, 7);
      cyc();
      expect_out($sformatf("lnext%0d", s), 8'((s + 1) % 4), 1'b1, 1'b0, 1'b1, 1'b0);
    end
    hold_step("l2s0", 8'd0, 1, 7);
    cyc();
    expect_out("l2s1", 8'd1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Pause mid step 1: pulse sampled at tick 4 leaves tick_cnt parked at 5
    hold_step("pre_pause", 8'd1, 1, 4);
    pause = 1'b1; cyc(); pause = 1'b0;
    expect_out("paused", 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) begin
      cyc();
      expect_out($sformatf("paused%0d", i), 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    pause = 1'b1; cyc(); pause = 1'b0;
    expect_out("resume.t5", 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    expect_out("resume.t6", 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    expect_out("resume.t7", 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    expect_out("resume.step2", 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);

    // Tempo change applies only at the next step boundary
    stop = 1'b1; cyc(); stop = 1'b0;
    expect_out("stop", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    loop_en = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    expect_out("tstart", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    hold_step("ts0a", 8'd0, 1, 3);
    tempo_sel = 2'b10;
    hold_step("ts0b", 8'd0, 4, 7);
    cyc();
    expect_out("tstep1", 8'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    hold_step("ts1", 8'd1, 1, 3);
    cyc();
    expect_out("tstep2", 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
    expect_out("stop_start", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    expect_out("stop_start2", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of step 2
    tempo_sel = 2'b00;
    start = 1'b1; cyc(); start = 1'b0;
    expect_out("rstart", 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    hold_step("rs0", 8'd0, 1, 7);
    cyc();
    hold_step("rs1", 8'd1, 1, 7);
    cyc();
    expect_out("rstep2", 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    expect_out("rstep2.t1", 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("arst", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    expect_out("post_rst", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
